// File: rtl/imem_fetch_port.sv
// Instruction memory fetch port: BRAM-backed synchronous read, optional output stage,
// credit-managed response FIFO and a boot-loader write mode entered after draining.
module imem_fetch_port #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 1024,
    parameter     INIT_FILE  = "program.mem",
    parameter int OUT_REG    = 0
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     req_valid,
    output logic                     req_ready,
    input  logic [ADDR_WIDTH-1:0]    req_addr,
    output logic                     resp_valid,
    input  logic                     resp_ready,
    output logic [DATA_WIDTH-1:0]    resp_data,
    output logic [ADDR_WIDTH-1:0]    resp_addr,
    output logic                     resp_err,
    input  logic                     load_en,
    input  logic                     load_we,
    input  logic [$clog2(DEPTH)-1:0] load_addr,
    input  logic [DATA_WIDTH-1:0]    load_data,
    output logic                     busy
);
    localparam int IDX_W = $clog2(DEPTH);
    localparam int LAT   = 1 + OUT_REG;
    localparam int FD    = LAT + 1;
    localparam int PW    = $clog2(FD);
    localparam int CW    = $clog2(FD + 1);

    typedef enum logic [1:0] {S_RUN, S_DRAIN, S_LOAD} state_t;

    state_t                  state_reg, state_next;
    logic                    req_fire, req_err;
    logic [IDX_W-1:0]        req_idx;
    logic [DATA_WIDTH-1:0]   mem [DEPTH];
    logic [DATA_WIDTH-1:0]   rd_data_reg;
    logic                    s1_valid_reg, s1_err_reg;
    logic [ADDR_WIDTH-1:0]   s1_addr_reg;
    logic                    pipe_valid, pipe_err;
    logic [DATA_WIDTH-1:0]   pipe_data;
    logic [ADDR_WIDTH-1:0]   pipe_addr;
    logic [1:0]              in_flight;
    logic [DATA_WIDTH-1:0]   fifo_data [FD];
    logic [ADDR_WIDTH-1:0]   fifo_addr [FD];
    logic [FD-1:0]           fifo_err;
    logic [PW-1:0]           wr_ptr_reg, rd_ptr_reg;
    logic [CW-1:0]           count_reg;
    logic                    fifo_empty, push, pop;
    logic [2:0]              occupancy;

    assign req_fire = req_valid && req_ready;
    assign req_idx  = req_addr[IDX_W+1:2];
    // Any address bit above the word-index field means the PC is outside the array.
    assign req_err  = (req_addr[1:0] != 2'b00) || ((req_addr >> (IDX_W + 2)) != '0);

    // Reads happen only in RUN and writes only in LOAD, so the ports never collide.
    always_ff @(posedge clk) begin
        if (state_reg == S_LOAD && load_we)
            mem[load_addr] <= load_data;
        if (req_fire)
            rd_data_reg <= mem[req_idx];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid_reg <= 1'b0;
            s1_err_reg   <= 1'b0;
            s1_addr_reg  <= '0;
        end else begin
            s1_valid_reg <= req_fire;
            if (req_fire) begin
                s1_addr_reg <= req_addr;
                s1_err_reg  <= req_err;
            end
        end
    end

    generate
        if (OUT_REG != 0) begin : g_out_reg
            logic                  s2_valid_reg, s2_err_reg;
            logic [DATA_WIDTH-1:0] s2_data_reg;
            logic [ADDR_WIDTH-1:0] s2_addr_reg;

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    s2_valid_reg <= 1'b0;
                    s2_err_reg   <= 1'b0;
                    s2_data_reg  <= '0;
                    s2_addr_reg  <= '0;
                end else begin
                    s2_valid_reg <= s1_valid_reg;
                    if (s1_valid_reg) begin
                        s2_err_reg  <= s1_err_reg;
                        s2_addr_reg <= s1_addr_reg;
                        s2_data_reg <= s1_err_reg ? '0 : rd_data_reg;
                    end
                end
            end
            assign pipe_valid = s2_valid_reg;
            assign pipe_err   = s2_err_reg;
            assign pipe_data  = s2_data_reg;
            assign pipe_addr  = s2_addr_reg;
            assign in_flight  = {1'b0, s1_valid_reg} + {1'b0, s2_valid_reg};
        end else begin : g_no_out_reg
            assign pipe_valid = s1_valid_reg;
            assign pipe_err   = s1_err_reg;
            assign pipe_data  = s1_err_reg ? '0 : rd_data_reg;
            assign pipe_addr  = s1_addr_reg;
            assign in_flight  = {1'b0, s1_valid_reg};
        end
    endgenerate

    // Fall-through: an empty FIFO lets the pipeline result straight to the outputs;
    // it is only captured when it cannot be consumed in the same cycle.
    assign fifo_empty = (count_reg == '0);
    assign pop        = !fifo_empty && resp_ready;
    assign push       = pipe_valid && !(fifo_empty && resp_ready);

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_data[wr_ptr_reg] <= pipe_data;
            fifo_addr[wr_ptr_reg] <= pipe_addr;
            fifo_err[wr_ptr_reg]  <= pipe_err;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (push)
                wr_ptr_reg <= (wr_ptr_reg == PW'(FD - 1)) ? '0 : wr_ptr_reg + 1'b1;
            if (pop)
                rd_ptr_reg <= (rd_ptr_reg == PW'(FD - 1)) ? '0 : rd_ptr_reg + 1'b1;
            count_reg <= count_reg + CW'(push) - CW'(pop);
        end
    end

    always_comb begin
        resp_valid = !fifo_empty || pipe_valid;
        resp_data  = '0;
        resp_addr  = '0;
        resp_err   = 1'b0;
        if (!fifo_empty) begin
            resp_data = fifo_data[rd_ptr_reg];
            resp_addr = fifo_addr[rd_ptr_reg];
            resp_err  = fifo_err[rd_ptr_reg];
        end else if (pipe_valid) begin
            resp_data = pipe_data;
            resp_addr = pipe_addr;
            resp_err  = pipe_err;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state_reg <= S_RUN;
        else
            state_reg <= state_next;
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            S_RUN:   if (load_en) state_next = S_DRAIN;
            S_DRAIN: begin
                if (!load_en)
                    state_next = S_RUN;
                else if (in_flight == 2'd0 && fifo_empty)
                    state_next = S_LOAD;
            end
            S_LOAD:  if (!load_en) state_next = S_RUN;
            default: state_next = S_RUN;
        endcase
    end

    // Credits cover pipeline plus FIFO, so a push can never find the FIFO full.
    assign occupancy = 3'(in_flight) + 3'(count_reg);

    always_comb begin
        req_ready = (state_reg == S_RUN) && (occupancy < 3'(FD));
        busy      = (state_reg != S_RUN);
    end
endmodule

// File: tb/tb_imem_fetch_port.sv
// Runs one instance per output-register setting on shared stimulus and checks both
// against a transaction-level model (expected-response queue plus memory image).
module tb_imem_fetch_port;
    localparam int AW    = 32;
    localparam int DW    = 32;
    localparam int DEPTH = 16;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            req_valid = 1'b0;
    logic            resp_ready = 1'b0;
    logic            load_en = 1'b0;
    logic            load_we = 1'b0;
    logic [AW-1:0]   req_addr = '0;
    logic [3:0]      load_addr = '0;
    logic [DW-1:0]   load_data = '0;
    logic [1:0]      req_ready, resp_valid, resp_err, busy;
    logic [DW-1:0]   resp_data [2];
    logic [AW-1:0]   resp_addr [2];

    always #5 clk = ~clk;

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_dut
            imem_fetch_port #(
                .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .DEPTH(DEPTH),
                .INIT_FILE(""), .OUT_REG(gi)
            ) u_dut (
                .clk(clk), .rst(rst),
                .req_valid(req_valid), .req_ready(req_ready[gi]), .req_addr(req_addr),
                .resp_valid(resp_valid[gi]), .resp_ready(resp_ready),
                .resp_data(resp_data[gi]), .resp_addr(resp_addr[gi]), .resp_err(resp_err[gi]),
                .load_en(load_en), .load_we(load_we), .load_addr(load_addr),
                .load_data(load_data), .busy(busy[gi])
            );
        end
    endgenerate

    typedef struct {
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
        logic          err;
        int            rdy;
    } exp_t;

    exp_t          ring [2][8];
    int            head [2];
    int            cnt [2];
    int            mode [2];      // 0 RUN, 1 DRAIN, 2 LOAD
    int            pushes [2];
    int            dut_pops [2];
    logic [DW-1:0] mm [2][DEPTH];
    int            cyc = 0;
    int            checks = 0;
    int            errors = 0;

    // Compare both DUTs against the model for the current cycle, then advance one clock.
    task automatic tick();
        bit exp_rdy [2];
        bit exp_val [2];
        int pre_cnt;
        for (int d = 0; d < 2; d++) begin
            exp_t f;
            exp_rdy[d] = (mode[d] == 0) && (cnt[d] < d + 2);
            exp_val[d] = (cnt[d] > 0) && (ring[d][head[d]].rdy <= cyc);
            f = ring[d][head[d]];
            checks++;
            if (req_ready[d] !== exp_rdy[d]) begin
                errors++;
                $display("FAIL req_ready dut%0d cyc %0d got %b exp %b", d, cyc, req_ready[d], exp_rdy[d]);
            end
            checks++;
            if (busy[d] !== (mode[d] != 0)) begin
                errors++;
                $display("FAIL busy dut%0d cyc %0d got %b exp %b", d, cyc, busy[d], mode[d] != 0);
            end
            checks++;
            if (resp_valid[d] !== exp_val[d]) begin
                errors++;
                $display("FAIL resp_valid dut%0d cyc %0d got %b exp %b", d, cyc, resp_valid[d], exp_val[d]);
            end
            if (exp_val[d]) begin
                checks += 3;
                if (resp_data[d] !== f.data) begin
                    errors++;
                    $display("FAIL resp_data dut%0d cyc %0d got %h exp %h", d, cyc, resp_data[d], f.data);
                end
                if (resp_addr[d] !== f.addr) begin
                    errors++;
                    $display("FAIL resp_addr dut%0d cyc %0d got %h exp %h", d, cyc, resp_addr[d], f.addr);
                end
                if (resp_err[d] !== f.err) begin
                    errors++;
                    $display("FAIL resp_err dut%0d cyc %0d got %b exp %b", d, cyc, resp_err[d], f.err);
                end
            end
            if (resp_valid[d] === 1'b1 && resp_ready) dut_pops[d]++;
        end
        for (int d = 0; d < 2; d++) begin
            pre_cnt = cnt[d];
            if (exp_val[d] && resp_ready) begin
                head[d] = (head[d] + 1) % 8;
                cnt[d]--;
            end
            if (req_valid && exp_rdy[d]) begin
                exp_t e;
                e.addr = req_addr;
                e.err  = (req_addr % 4 != 0) || (req_addr / 4 >= DEPTH);
                e.data = '0;
                if (!e.err) e.data = mm[d][req_addr / 4];
                e.rdy  = cyc + d + 1;
                ring[d][(head[d] + cnt[d]) % 8] = e;
                cnt[d]++;
                pushes[d]++;
            end
            if (mode[d] == 2 && load_we) mm[d][load_addr] = load_data;
            case (mode[d])
                0: if (load_en) mode[d] = 1;
                1: if (!load_en) mode[d] = 0; else if (pre_cnt == 0) mode[d] = 2;
                default: if (!load_en) mode[d] = 0;
            endcase
        end
        @(posedge clk);
        @(negedge clk);
        cyc++;
    endtask

    task automatic drain();
        req_valid  = 1'b0;
        resp_ready = 1'b1;
        load_we    = 1'b0;
        for (int n = 0; n < 30 && (cnt[0] > 0 || cnt[1] > 0); n++) tick();
        tick();
    endtask

    task automatic test_reset();
        for (int d = 0; d < 2; d++) begin
            cnt[d] = 0; head[d] = 0; mode[d] = 0; pushes[d] = 0; dut_pops[d] = 0;
        end
        rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            checks++;
            if (resp_valid[d] !== 1'b0 || busy[d] !== 1'b0 || resp_err[d] !== 1'b0) begin
                errors++;
                $display("FAIL reset_flags dut%0d got v%b b%b e%b exp 000", d, resp_valid[d], busy[d], resp_err[d]);
            end
            checks++;
            if (resp_data[d] !== '0 || resp_addr[d] !== '0) begin
                errors++;
                $display("FAIL reset_data dut%0d got %h/%h exp 0/0", d, resp_data[d], resp_addr[d]);
            end
            checks++;
            if (req_ready[d] !== 1'b1) begin
                errors++;
                $display("FAIL reset_ready dut%0d got %b exp 1", d, req_ready[d]);
            end
        end
        rst = 1'b0;
        tick();
    endtask

    task automatic boot_load();
        logic [DW-1:0] img [4];
        img[0] = 32'h13; img[1] = 32'h93; img[2] = 32'h113; img[3] = 32'h193;
        req_valid = 1'b0;
        resp_ready = 1'b1;
        load_en = 1'b1;
        for (int n = 0; n < 20 && (mode[0] != 2 || mode[1] != 2); n++) tick();
        for (int i = 0; i < DEPTH; i++) begin
            load_we   = 1'b1;
            load_addr = 4'(i);
            load_data = (i < 4) ? img[i] : $urandom;
            tick();
        end
        load_we = 1'b0;
        load_en = 1'b0;
        tick();
    endtask

    task automatic test_back_to_back();
        int p0 [2];
        int d0 [2];
        p0 = pushes;
        d0 = dut_pops;
        resp_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            req_valid = 1'b1;
            req_addr  = 32'(i * 4);
            tick();
        end
        drain();
        for (int d = 0; d < 2; d++) begin
            checks++;
            if (dut_pops[d] - d0[d] != 4 || pushes[d] - p0[d] != 4) begin
                errors++;
                $display("FAIL b2b_count dut%0d got %0d exp 4", d, dut_pops[d] - d0[d]);
            end
        end
    endtask

    task automatic test_backpressure();
        int p0 [2];
        int d0 [2];
        p0 = pushes;
        d0 = dut_pops;
        for (int i = 0; i < 8; i++) begin
            req_valid  = 1'b1;
            req_addr   = 32'((i % DEPTH) * 4);
            resp_ready = (i < 2);
            tick();
        end
        for (int d = 0; d < 2; d++) begin
            checks++;
            if (req_ready[d] !== 1'b0 || resp_valid[d] !== 1'b1) begin
                errors++;
                $display("FAIL bp_stall dut%0d got rdy%b val%b exp rdy0 val1", d, req_ready[d], resp_valid[d]);
            end
        end
        drain();
        for (int d = 0; d < 2; d++) begin
            checks++;
            if (dut_pops[d] - d0[d] != pushes[d] - p0[d]) begin
                errors++;
                $display("FAIL bp_count dut%0d got %0d exp %0d", d, dut_pops[d] - d0[d], pushes[d] - p0[d]);
            end
        end
    endtask

    task automatic test_errors();
        logic [AW-1:0] addrs [3];
        addrs[0] = 32'h6; addrs[1] = 32'(DEPTH * 4); addrs[2] = 32'h0;
        resp_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            req_valid = 1'b1;
            req_addr  = addrs[i];
            tick();
        end
        drain();
    endtask

    task automatic test_load_drain();
        int d0 [2];
        d0 = dut_pops;
        resp_ready = 1'b0;
        for (int i = 0; i < 2; i++) begin
            req_valid = 1'b1;
            req_addr  = 32'(i * 4);
            tick();
        end
        req_valid = 1'b0;
        load_en   = 1'b1;
        repeat (4) tick();
        checks++;
        if (busy !== 2'b11 || resp_valid !== 2'b11) begin
            errors++;
            $display("FAIL drain_hold got busy %b valid %b exp 11 11", busy, resp_valid);
        end
        resp_ready = 1'b1;
        for (int n = 0; n < 20 && (mode[0] != 2 || mode[1] != 2); n++) tick();
        load_we   = 1'b1;
        load_addr = 4'd1;
        load_data = 32'hDEADBEEF;
        tick();
        load_we = 1'b0;
        load_en = 1'b0;
        tick();
        req_valid = 1'b1;
        req_addr  = 32'h4;
        tick();
        drain();
        for (int d = 0; d < 2; d++) begin
            checks++;
            if (dut_pops[d] - d0[d] != 3) begin
                errors++;
                $display("FAIL load_drain_count dut%0d got %0d exp 3", d, dut_pops[d] - d0[d]);
            end
        end
    endtask

    task automatic test_load_we_in_run();
        resp_ready = 1'b1;
        req_valid  = 1'b0;
        load_we    = 1'b1;
        load_addr  = 4'd2;
        load_data  = 32'hBAD0BAD0;
        tick();
        load_we   = 1'b0;
        req_valid = 1'b1;
        req_addr  = 32'h8;
        tick();
        drain();
    endtask

    task automatic test_random();
        int p0 [2];
        int d0 [2];
        p0 = pushes;
        d0 = dut_pops;
        for (int i = 0; i < 400; i++) begin
            req_valid = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 7) == 0)
                req_addr = $urandom_range(0, 80);
            else
                req_addr = $urandom_range(0, DEPTH - 1) * 4;
            resp_ready = ($urandom_range(0, 3) != 0);
            tick();
        end
        drain();
        for (int d = 0; d < 2; d++) begin
            checks++;
            if (dut_pops[d] - d0[d] != pushes[d] - p0[d]) begin
                errors++;
                $display("FAIL random_count dut%0d got %0d exp %0d", d, dut_pops[d] - d0[d], pushes[d] - p0[d]);
            end
        end
    endtask

    task automatic test_reset_inflight();
        resp_ready = 1'b0;
        for (int i = 0; i < 2; i++) begin
            req_valid = 1'b1;
            req_addr  = 32'(i * 4 + 4);
            tick();
        end
        req_valid = 1'b0;
        rst = 1'b1;
        #1;
        checks++;
        if (resp_valid !== 2'b00 || busy !== 2'b00) begin
            errors++;
            $display("FAIL reset_inflight got valid %b busy %b exp 00 00", resp_valid, busy);
        end
        for (int d = 0; d < 2; d++) begin
            cnt[d] = 0; head[d] = 0; mode[d] = 0;
            checks++;
            if (resp_data[d] !== '0) begin
                errors++;
                $display("FAIL reset_inflight_data dut%0d got %h exp 0", d, resp_data[d]);
            end
        end
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        cyc++;
        resp_ready = 1'b1;
        repeat (4) tick();
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog expired at cyc %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        boot_load();
        test_back_to_back();
        test_backpressure();
        test_errors();
        test_load_drain();
        test_load_we_in_run();
        test_random();
        test_reset_inflight();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
